// File: rtl/acc_ctrl_fsm_if.sv
// Control bus between the accumulator-core sequencer and its datapath.
//   master : the sequencer (acc_ctrl_fsm) - drives enables, selects, status
//   slave  : the datapath - drives run, opcode and the ALU/ACC flags
// Signals:
//   run, opcode[OPW-1:0], acc_zero, alu_ovfl                 datapath -> sequencer
//   pc_write, ir_write, acc_write, sp_write, mem_write,
//   out_write, mem_addr_sel[1:0], alu_src_a[1:0],
//   alu_src_b[1:0], alu_op[2:0], acc_src[1:0], pc_src        sequencer -> datapath
//   ovfl_trap, state_dbg[STW-1:0]                            sequencer status
interface acc_ctrl_fsm_if #(
    parameter int OPW = 4,
    parameter int STW = 4
);
    logic           run;
    logic [OPW-1:0] opcode;
    logic           acc_zero;
    logic           alu_ovfl;

    logic           pc_write;
    logic           ir_write;
    logic           acc_write;
    logic           sp_write;
    logic           mem_write;
    logic           out_write;
    logic [1:0]     mem_addr_sel;
    logic [1:0]     alu_src_a;
    logic [1:0]     alu_src_b;
    logic [2:0]     alu_op;
    logic [1:0]     acc_src;
    logic           pc_src;
    logic           ovfl_trap;
    logic [STW-1:0] state_dbg;

    modport master (
        input  run, opcode, acc_zero, alu_ovfl,
        output pc_write, ir_write, acc_write, sp_write, mem_write, out_write,
               mem_addr_sel, alu_src_a, alu_src_b, alu_op, acc_src, pc_src,
               ovfl_trap, state_dbg
    );

    modport slave (
        output run, opcode, acc_zero, alu_ovfl,
        input  pc_write, ir_write, acc_write, sp_write, mem_write, out_write,
               mem_addr_sel, alu_src_a, alu_src_b, alu_op, acc_src, pc_src,
               ovfl_trap, state_dbg
    );
endinterface

// File: rtl/acc_ctrl_fsm.sv
// Multicycle control unit for the 16-bit accumulator core. Decodes the IR
// opcode and sequences every datapath write enable and mux select, one state
// per cycle.
// Ports:
//   CLK    in  rising-edge clock
//   reset  in  asynchronous active-low reset; forces FETCH, clears outputs
//   bus    acc_ctrl_fsm_if.master (inputs run/opcode/acc_zero/alu_ovfl,
//          outputs enables, selects, ovfl_trap, state_dbg)
//
// state    | meaning
// FETCH    | IR <= mem[PC], PC <= PC+1 (only while run=1)
// DECODE   | opcode selects the next state
// EXEC_I   | ACC <= ACC op IMM (li/addi/andi/ori)
// MEM_RD   | read mem[IMM]
// EXEC_M   | ACC <= ACC op MEMOUT (add/and/sub)
// LW_WB    | ACC <= MEMOUT
// MEM_WR   | mem[IMM] <= ACC
// BRANCH   | PC <= IMM if the beqz/bnez condition holds
// JUMP     | PC <= IMM
// PUSH_DEC | SP <= SP-1
// PUSH_WR  | mem[SP] <= ACC
// POP_RD   | read mem[SP]
// POP_WB   | ACC <= MEMOUT, SP <= SP+1
// IO_IN    | ACC <= FPGAIn
// IO_OUT   | FPGAOut <= ACC
// HALT     | overflow trap; frozen until reset
module acc_ctrl_fsm #(
    parameter int OPW       = 4,
    parameter int STW       = 4,
    parameter bit OVFL_TRAP = 1'b1
) (
    input logic           CLK,
    input logic           reset,
    acc_ctrl_fsm_if.master bus
);
    typedef enum logic [STW-1:0] {
        FETCH    = STW'(0),
        DECODE   = STW'(1),
        EXEC_I   = STW'(2),
        MEM_RD   = STW'(3),
        EXEC_M   = STW'(4),
        LW_WB    = STW'(5),
        MEM_WR   = STW'(6),
        BRANCH   = STW'(7),
        JUMP     = STW'(8),
        PUSH_DEC = STW'(9),
        PUSH_WR  = STW'(10),
        POP_RD   = STW'(11),
        POP_WB   = STW'(12),
        IO_IN    = STW'(13),
        IO_OUT   = STW'(14),
        HALT     = STW'(15)
    } state_t;

    localparam logic [OPW-1:0] OP_LI   = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(2);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
    localparam logic [OPW-1:0] OP_LW   = OPW'(7);
    localparam logic [OPW-1:0] OP_SW   = OPW'(8);
    localparam logic [OPW-1:0] OP_BEQZ = OPW'(9);
    localparam logic [OPW-1:0] OP_BNEZ = OPW'(10);
    localparam logic [OPW-1:0] OP_J    = OPW'(11);
    localparam logic [OPW-1:0] OP_PUSH = OPW'(12);
    localparam logic [OPW-1:0] OP_POP  = OPW'(13);
    localparam logic [OPW-1:0] OP_IN   = OPW'(14);

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    localparam logic [1:0] MAS_PC  = 2'd0;
    localparam logic [1:0] MAS_IMM = 2'd1;
    localparam logic [1:0] MAS_SP  = 2'd2;
    localparam logic [1:0] SA_ACC  = 2'd0;
    localparam logic [1:0] SA_PC   = 2'd1;
    localparam logic [1:0] SA_SP   = 2'd2;
    localparam logic [1:0] SB_IMM  = 2'd0;
    localparam logic [1:0] SB_MEM  = 2'd1;
    localparam logic [1:0] SB_ONE  = 2'd2;
    localparam logic [1:0] AS_MEM  = 2'd1;
    localparam logic [1:0] AS_IN   = 2'd2;

    state_t     state_q, state_nxt;

    // Output registers hold the decode of the state being entered, so each
    // state's outputs come straight from flops. The few flag-dependent terms
    // (run in FETCH, acc_zero in BRANCH, alu_ovfl in EXEC_*) are qualified
    // combinationally below because those inputs are only valid in-state.
    logic       fetch_q, jump_q, branch_q, br_zero_q, ovfl_chk_q;
    logic       acc_wr_q, sp_wr_q, mem_wr_q, out_wr_q, pc_src_q;
    logic [1:0] mas_q, src_a_q, src_b_q, acc_src_q;
    logic [2:0] alu_op_q;
    logic       ovfl_trap_q;

    logic       d_fetch, d_jump, d_branch, d_br_zero, d_ovfl_chk;
    logic       d_acc_wr, d_sp_wr, d_mem_wr, d_out_wr, d_pc_src;
    logic [1:0] d_mas, d_src_a, d_src_b, d_acc_src;
    logic [2:0] d_alu_op;
    logic       trap_now;

    assign trap_now = ovfl_chk_q & bus.alu_ovfl;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            FETCH:    if (bus.run) state_nxt = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LI, OP_ADDI, OP_ANDI, OP_ORI: state_nxt = EXEC_I;
                    OP_ADD, OP_AND, OP_SUB, OP_LW:   state_nxt = MEM_RD;
                    OP_SW:                           state_nxt = MEM_WR;
                    OP_BEQZ, OP_BNEZ:                state_nxt = BRANCH;
                    OP_J:                            state_nxt = JUMP;
                    OP_PUSH:                         state_nxt = PUSH_DEC;
                    OP_POP:                          state_nxt = POP_RD;
                    OP_IN:                           state_nxt = IO_IN;
                    default:                         state_nxt = IO_OUT;
                endcase
            end
            EXEC_I, EXEC_M: state_nxt = trap_now ? HALT : FETCH;
            MEM_RD:   state_nxt = (bus.opcode == OP_LW) ? LW_WB : EXEC_M;
            PUSH_DEC: state_nxt = PUSH_WR;
            POP_RD:   state_nxt = POP_WB;
            HALT:     state_nxt = HALT;
            default:  state_nxt = FETCH;
        endcase

        d_fetch    = 1'b0;
        d_jump     = 1'b0;
        d_branch   = 1'b0;
        d_br_zero  = 1'b0;
        d_ovfl_chk = 1'b0;
        d_acc_wr   = 1'b0;
        d_sp_wr    = 1'b0;
        d_mem_wr   = 1'b0;
        d_out_wr   = 1'b0;
        d_pc_src   = 1'b0;
        d_mas      = MAS_PC;
        d_src_a    = SA_ACC;
        d_src_b    = SB_IMM;
        d_acc_src  = 2'd0;
        d_alu_op   = ALU_PASS;
        case (state_nxt)
            FETCH: begin
                d_fetch  = 1'b1;
                d_mas    = MAS_PC;
                d_src_a  = SA_PC;
                d_src_b  = SB_ONE;
                d_alu_op = ALU_ADD;
            end
            EXEC_I: begin
                d_acc_wr   = 1'b1;
                d_ovfl_chk = OVFL_TRAP && (bus.opcode == OP_ADDI);
                case (bus.opcode)
                    OP_ADDI: d_alu_op = ALU_ADD;
                    OP_ANDI: d_alu_op = ALU_AND;
                    OP_ORI:  d_alu_op = ALU_OR;
                    default: d_alu_op = ALU_PASS;
                endcase
            end
            MEM_RD: d_mas = MAS_IMM;
            EXEC_M: begin
                d_acc_wr   = 1'b1;
                d_src_b    = SB_MEM;
                d_ovfl_chk = OVFL_TRAP && ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB));
                case (bus.opcode)
                    OP_AND:  d_alu_op = ALU_AND;
                    OP_SUB:  d_alu_op = ALU_SUB;
                    default: d_alu_op = ALU_ADD;
                endcase
            end
            LW_WB: begin
                d_acc_wr  = 1'b1;
                d_acc_src = AS_MEM;
            end
            MEM_WR: begin
                d_mas    = MAS_IMM;
                d_mem_wr = 1'b1;
            end
            BRANCH: begin
                d_pc_src  = 1'b1;
                d_branch  = 1'b1;
                d_br_zero = (bus.opcode == OP_BEQZ);
            end
            JUMP: begin
                d_pc_src = 1'b1;
                d_jump   = 1'b1;
            end
            PUSH_DEC: begin
                d_src_a  = SA_SP;
                d_src_b  = SB_ONE;
                d_alu_op = ALU_SUB;
                d_sp_wr  = 1'b1;
            end
            PUSH_WR: begin
                d_mas    = MAS_SP;
                d_mem_wr = 1'b1;
            end
            POP_RD: d_mas = MAS_SP;
            POP_WB: begin
                // ACC takes MEMOUT, so the ALU is free for SP+1
                d_acc_wr  = 1'b1;
                d_acc_src = AS_MEM;
                d_src_a   = SA_SP;
                d_src_b   = SB_ONE;
                d_alu_op  = ALU_ADD;
                d_sp_wr   = 1'b1;
            end
            IO_IN: begin
                d_acc_wr  = 1'b1;
                d_acc_src = AS_IN;
            end
            IO_OUT:  d_out_wr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            // Reset lands in FETCH, so preload the FETCH decode.
            fetch_q     <= 1'b1;
            jump_q      <= 1'b0;
            branch_q    <= 1'b0;
            br_zero_q   <= 1'b0;
            ovfl_chk_q  <= 1'b0;
            acc_wr_q    <= 1'b0;
            sp_wr_q     <= 1'b0;
            mem_wr_q    <= 1'b0;
            out_wr_q    <= 1'b0;
            pc_src_q    <= 1'b0;
            mas_q       <= MAS_PC;
            src_a_q     <= SA_PC;
            src_b_q     <= SB_ONE;
            acc_src_q   <= 2'd0;
            alu_op_q    <= ALU_ADD;
            ovfl_trap_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            fetch_q     <= d_fetch;
            jump_q      <= d_jump;
            branch_q    <= d_branch;
            br_zero_q   <= d_br_zero;
            ovfl_chk_q  <= d_ovfl_chk;
            acc_wr_q    <= d_acc_wr;
            sp_wr_q     <= d_sp_wr;
            mem_wr_q    <= d_mem_wr;
            out_wr_q    <= d_out_wr;
            pc_src_q    <= d_pc_src;
            mas_q       <= d_mas;
            src_a_q     <= d_src_a;
            src_b_q     <= d_src_b;
            acc_src_q   <= d_acc_src;
            alu_op_q    <= d_alu_op;
            if (trap_now) ovfl_trap_q <= 1'b1;
        end
    end

    // reset gates every output so an in-flight write dies the moment reset
    // falls rather than at the next edge.
    assign bus.ir_write     = reset & fetch_q & bus.run;
    assign bus.pc_write     = reset & ((fetch_q & bus.run) | jump_q |
                                       (branch_q & (bus.acc_zero == br_zero_q)));
    assign bus.acc_write    = reset & acc_wr_q & ~trap_now;
    assign bus.sp_write     = reset & sp_wr_q;
    assign bus.mem_write    = reset & mem_wr_q;
    assign bus.out_write    = reset & out_wr_q;
    assign bus.pc_src       = reset & pc_src_q;
    assign bus.mem_addr_sel = reset ? mas_q     : 2'd0;
    assign bus.alu_src_a    = reset ? src_a_q   : 2'd0;
    assign bus.alu_src_b    = reset ? src_b_q   : 2'd0;
    assign bus.acc_src      = reset ? acc_src_q : 2'd0;
    assign bus.alu_op       = reset ? alu_op_q  : 3'd0;
    assign bus.ovfl_trap    = ovfl_trap_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_acc_ctrl_fsm.sv
module tb_acc_ctrl_fsm;
    logic CLK = 1'b0;
    logic reset;

    acc_ctrl_fsm_if #(.OPW(4), .STW(4)) bus ();

    acc_ctrl_fsm #(.OPW(4), .STW(4), .OVFL_TRAP(1'b1)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam logic [22:0] FULL   = 23'h7FFFFF;
    localparam logic [22:0] ENONLY = 23'h7FE001;   // state, enables, trap

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit m_trap = 1'b0;   // reference sticky overflow flag
    bit m_halt = 1'b0;   // reference says core is halted
    logic [22:0] exp_q[$];

    // ALU operation each opcode asks for in its execute step
    int alu_of [16] = '{0, 1, 3, 4, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    function automatic logic [22:0] mk(input int st, input bit pcw, irw, accw, spw, memw, outw,
                                       input int mas, sa, sb, aop, asrc, input bit psrc);
        return {4'(st), pcw, irw, accw, spw, memw, outw,
                2'(mas), 2'(sa), 2'(sb), 3'(aop), 2'(asrc), psrc, m_trap};
    endfunction

    function automatic logic [22:0] obs();
        return {bus.state_dbg, bus.pc_write, bus.ir_write, bus.acc_write, bus.sp_write,
                bus.mem_write, bus.out_write, bus.mem_addr_sel, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.acc_src, bus.pc_src, bus.ovfl_trap};
    endfunction

    task automatic cmp(input string tag, input logic [22:0] expv, input logic [22:0] mask);
        logic [22:0] o;
        o = obs();
        n_checks++;
        assert ((o & mask) === (expv & mask)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o & mask, expv & mask);
        end
    endtask

    task automatic step(input string tag, input logic [22:0] expv, input logic [22:0] mask);
        @(negedge CLK);
        cmp(tag, expv, mask);
        @(posedge CLK);
        #1;
    endtask

    // Expected per-cycle outputs of one instruction, from the opcode table.
    task automatic plan_instr(input int op, input bit az, input bit ov);
        bit trap;
        exp_q.push_back(mk(0, 1,1,0,0,0,0, 0,1,2,1,0, 0));
        exp_q.push_back(mk(1, 0,0,0,0,0,0, 0,0,0,0,0, 0));
        case (op)
            0, 1, 2, 3: begin
                trap = (op == 1) && ov;
                exp_q.push_back(mk(2, 0,0,!trap,0,0,0, 0,0,0,alu_of[op],0, 0));
                if (trap) begin m_trap = 1'b1; m_halt = 1'b1; end
            end
            4, 5, 6: begin
                trap = ((op == 4) || (op == 6)) && ov;
                exp_q.push_back(mk(3, 0,0,0,0,0,0, 1,0,0,0,0, 0));
                exp_q.push_back(mk(4, 0,0,!trap,0,0,0, 0,0,1,alu_of[op],0, 0));
                if (trap) begin m_trap = 1'b1; m_halt = 1'b1; end
            end
            7: begin
                exp_q.push_back(mk(3, 0,0,0,0,0,0, 1,0,0,0,0, 0));
                exp_q.push_back(mk(5, 0,0,1,0,0,0, 0,0,0,0,1, 0));
            end
            8:     exp_q.push_back(mk(6, 0,0,0,0,1,0, 1,0,0,0,0, 0));
            9, 10: exp_q.push_back(mk(7, (op == 9) ? az : !az,0,0,0,0,0, 0,0,0,0,0, 1));
            11:    exp_q.push_back(mk(8, 1,0,0,0,0,0, 0,0,0,0,0, 1));
            12: begin
                exp_q.push_back(mk(9,  0,0,0,1,0,0, 0,2,2,2,0, 0));
                exp_q.push_back(mk(10, 0,0,0,0,1,0, 2,0,0,0,0, 0));
            end
            13: begin
                exp_q.push_back(mk(11, 0,0,0,0,0,0, 2,0,0,0,0, 0));
                exp_q.push_back(mk(12, 0,0,1,1,0,0, 0,2,2,1,1, 0));
            end
            14:      exp_q.push_back(mk(13, 0,0,1,0,0,0, 0,0,0,0,2, 0));
            default: exp_q.push_back(mk(14, 0,0,0,0,0,1, 0,0,0,0,0, 0));
        endcase
    endtask

    task automatic run_instr(input int op, input bit az, input bit ov);
        int k;
        bus.run      = 1'b1;
        bus.opcode   = 4'($urandom_range(0, 15));   // IR not loaded yet
        bus.acc_zero = az;
        bus.alu_ovfl = ov;
        plan_instr(op, az, ov);
        k = 0;
        while (exp_q.size() > 0) begin
            step($sformatf("op%0d_c%0d", op, k), exp_q.pop_front(), FULL);
            if (k == 0) bus.opcode = 4'(op);
            k++;
        end
    endtask

    task automatic idle(input int n);
        bus.run = 1'b0;
        for (int i = 0; i < n; i++)
            step($sformatf("idle_c%0d", i), mk(0, 0,0,0,0,0,0, 0,0,0,0,0, 0), ENONLY);
    endtask

    task automatic halt_phase(input int n);
        for (int i = 0; i < n; i++) begin
            bus.run      = 1'($urandom_range(0, 1));
            bus.alu_ovfl = 1'($urandom_range(0, 1));
            step($sformatf("halt_c%0d", i), mk(15, 0,0,0,0,0,0, 0,0,0,0,0, 0), FULL);
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        cmp("rst_async", 23'h0, FULL);
        m_trap = 1'b0;
        m_halt = 1'b0;
        @(negedge CLK);
        cmp("rst_hold", 23'h0, FULL);
        @(posedge CLK);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        bit az, ov;

        reset        = 1'b0;
        bus.run      = 1'b1;
        bus.opcode   = 4'd0;
        bus.acc_zero = 1'b0;
        bus.alu_ovfl = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            cmp($sformatf("reset_c%0d", i), 23'h0, FULL);
        end
        @(posedge CLK);
        #1;
        reset = 1'b1;

        // li, add, beqz taken / not taken, push, pop
        run_instr(0, 1'b0, 1'b0);
        run_instr(4, 1'b0, 1'b0);
        run_instr(9, 1'b1, 1'b0);
        run_instr(9, 1'b0, 1'b0);
        run_instr(12, 1'b0, 1'b0);
        run_instr(13, 1'b0, 1'b0);

        // overflow ignored by andi, trapped by addi
        run_instr(2, 1'b0, 1'b1);
        run_instr(1, 1'b0, 1'b1);
        halt_phase(10);
        reset_pulse();

        // run=0 holds FETCH; then reset lands in the middle of lw
        idle(5);
        bus.run      = 1'b1;
        bus.opcode   = 4'd3;
        bus.alu_ovfl = 1'b0;
        plan_instr(7, 1'b0, 1'b0);
        step("lw_fetch", exp_q.pop_front(), FULL);
        bus.opcode = 4'd7;
        step("lw_decode", exp_q.pop_front(), FULL);
        @(negedge CLK);
        cmp("lw_memrd", exp_q.pop_front(), FULL);
        exp_q.delete();
        #2;
        reset = 1'b0;
        #1;
        cmp("rst_in_memrd", 23'h0, FULL);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            cmp($sformatf("rst_memrd_hold%0d", i), 23'h0, FULL);
        end
        @(posedge CLK);
        #1;
        reset = 1'b1;

        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 15);
            az = 1'($urandom_range(0, 1));
            ov = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            run_instr(op, az, ov);
            if (m_halt) begin
                halt_phase($urandom_range(1, 4));
                reset_pulse();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
